// File: rtl/size_conv_rx_64_to_32.sv
// Reads 64-bit MRAM words and streams them to the uDMA RX channel as 32-bit words, low half first.
// Build option: SIZE_CONV_RX_INV_DATA_EN makes the read buffer capture inverted MRAM data.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a command; grants every request, starts on read
// REQ      | MRAM read request at addr_q, waiting for grant
// WAIT     | read granted, waiting for rvalid to fill the buffer
// PUSH_LO  | offering buffer[31:0] on the RX stream
// PUSH_HI  | offering buffer[63:32] on the RX stream
// DONE     | one-cycle completion pulse
module size_conv_rx_64_to_32 #(
    parameter int         TRANS_SIZE  = 16,
    parameter logic [7:0] CMD_READ_RX = 8'h40
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  push_cmd_req_i,
    output logic                  push_cmd_gnt_o,
    input  logic [7:0]            mram_mode_i,
    input  logic [15:0]           data_rx_addr_i,
    input  logic [TRANS_SIZE-1:0] data_rx_size_i,

    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [15:0]           mem_addr_o,
    output logic                  mem_eot_o,
    input  logic [77:0]           mem_rdata_i,
    input  logic                  mem_rvalid_i,

    output logic [31:0]           data_rx_data_o,
    output logic                  data_rx_valid_o,
    input  logic                  data_rx_ready_i,

    output logic                  pending_o,
    output logic                  rx_done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_PUSH_LO,
        ST_PUSH_HI,
        ST_DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [15:0]           addr_q;
    logic [TRANS_SIZE-1:0] size_q;
    logic [63:0]           buf_q;
    logic [63:0]           rdata_cap;
    logic                  cmd_read;
    logic                  size_le4;
    logic                  size_le8;
    logic                  unused_rdata_hi;

    // ECC/tag bits above 63 are not part of the payload.
    assign unused_rdata_hi = ^mem_rdata_i[77:64];

`ifdef SIZE_CONV_RX_INV_DATA_EN
    assign rdata_cap = ~mem_rdata_i[63:0];
`else
    assign rdata_cap = mem_rdata_i[63:0];
`endif

    assign cmd_read = push_cmd_req_i && (mram_mode_i == CMD_READ_RX);
    // A size of 0 or a partial word falls under these compares, so both round up naturally.
    assign size_le4 = (size_q <= TRANS_SIZE'(4));
    assign size_le8 = (size_q <= TRANS_SIZE'(8));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_read) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_PUSH_LO;
                end
            end
            ST_PUSH_LO: begin
                if (data_rx_ready_i) begin
                    state_d = size_le4 ? ST_DONE : ST_PUSH_HI;
                end
            end
            ST_PUSH_HI: begin
                if (data_rx_ready_i) begin
                    state_d = size_le4 ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            size_q <= '0;
            buf_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_read) begin
                        addr_q <= data_rx_addr_i;
                        size_q <= data_rx_size_i;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        buf_q <= rdata_cap;
                    end
                end
                ST_PUSH_LO: begin
                    if (data_rx_ready_i && !size_le4) begin
                        size_q <= size_q - TRANS_SIZE'(4);
                    end
                end
                ST_PUSH_HI: begin
                    if (data_rx_ready_i && !size_le4) begin
                        size_q <= size_q - TRANS_SIZE'(4);
                        addr_q <= addr_q + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        push_cmd_gnt_o  = 1'b0;
        mem_req_o       = 1'b0;
        mem_eot_o       = 1'b0;
        data_rx_data_o  = '0;
        data_rx_valid_o = 1'b0;
        rx_done_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                push_cmd_gnt_o = push_cmd_req_i;
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                mem_eot_o = size_le8;
            end
            ST_PUSH_LO: begin
                data_rx_valid_o = 1'b1;
                data_rx_data_o  = buf_q[31:0];
            end
            ST_PUSH_HI: begin
                data_rx_valid_o = 1'b1;
                data_rx_data_o  = buf_q[63:32];
            end
            ST_DONE: begin
                rx_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_addr_o = addr_q;
    assign pending_o  = push_cmd_req_i || (state_q != ST_IDLE);

endmodule

// File: tb/tb_size_conv_rx_64_to_32.sv
// Scoreboard bench for size_conv_rx_64_to_32: MRAM responder and RX consumer check against queued expectations.
// Follows SIZE_CONV_RX_INV_DATA_EN when choosing how the memory model stores data.
module tb_size_conv_rx_64_to_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_cmd_req_i;
    logic        push_cmd_gnt_o;
    logic [7:0]  mram_mode_i;
    logic [15:0] data_rx_addr_i;
    logic [15:0] data_rx_size_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [15:0] mem_addr_o;
    logic        mem_eot_o;
    logic [77:0] mem_rdata_i;
    logic        mem_rvalid_i;
    logic [31:0] data_rx_data_o;
    logic        data_rx_valid_o;
    logic        data_rx_ready_i;
    logic        pending_o;
    logic        rx_done_o;

    size_conv_rx_64_to_32 #(.TRANS_SIZE(16), .CMD_READ_RX(8'h40)) dut (
        .clk             (clk),
        .rst             (rst),
        .push_cmd_req_i  (push_cmd_req_i),
        .push_cmd_gnt_o  (push_cmd_gnt_o),
        .mram_mode_i     (mram_mode_i),
        .data_rx_addr_i  (data_rx_addr_i),
        .data_rx_size_i  (data_rx_size_i),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_eot_o       (mem_eot_o),
        .mem_rdata_i     (mem_rdata_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .data_rx_data_o  (data_rx_data_o),
        .data_rx_valid_o (data_rx_valid_o),
        .data_rx_ready_i (data_rx_ready_i),
        .pending_o       (pending_o),
        .rx_done_o       (rx_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic        eot;
    } rd_t;

    int          total = 0;
    int          bad = 0;
    rd_t         rd_q[$];
    logic [31:0] wd_q[$];
    int          exp_done = 0;
    int          done_seen = 0;
    int          hs_total = 0;
    int          stall_at = -1;
    bit          ovr_en = 1'b0;
    logic [63:0] ovr_val = '0;
    bit          rand_rdy = 1'b1;
    bit          hold_rdy = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        if (ovr_en) return ovr_val;
        return {8'hB0, a, 8'h4E, a ^ 16'h1357, ~a};
    endfunction

    // MRAM model: random grant, rvalid 1..3 cycles after the grant
    initial begin
        int          rv_cnt;
        logic [63:0] rv_w;
        logic [63:0] raw;
        rd_t         e;
        rv_cnt       = -1;
        rv_w         = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (rv_cnt == 0) begin
`ifdef SIZE_CONV_RX_INV_DATA_EN
                raw = ~rv_w;
`else
                raw = rv_w;
`endif
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = {14'($urandom), raw};
                rv_cnt       = -1;
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = {14'($urandom), 32'($urandom), 32'($urandom)};
                if (rv_cnt > 0) rv_cnt--;
            end
            if (mem_req_o && !rst && $urandom_range(0, 2) != 0) begin
                mem_gnt_i = 1'b1;
                check_val("mem_req_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    check_val("mem_addr", mem_addr_o, e.a);
                    check_val("mem_eot", mem_eot_o, e.eot);
                end
                rv_w   = mem_word(mem_addr_o);
                rv_cnt = $urandom_range(0, 2);
            end else begin
                mem_gnt_i = 1'b0;
            end
        end
    end

    // RX consumer with optional 5-cycle stall on a chosen word
    initial begin
        int   stall_left;
        logic r;
        stall_left      = 0;
        data_rx_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (data_rx_valid_o && hs_total == stall_at && stall_left < 5) begin
                if (wd_q.size() != 0) check_val("stall_data", data_rx_data_o, wd_q[0]);
                check_val("stall_valid_noreq", {data_rx_valid_o, mem_req_o}, 2'b10);
                stall_left++;
                r = 1'b0;
            end else if (hold_rdy || rst) begin
                r = 1'b0;
            end else if (rand_rdy) begin
                r = ($urandom_range(0, 3) != 0);
            end else begin
                r = 1'b1;
            end
            data_rx_ready_i = r;
            if (data_rx_valid_o && r) begin
                check_val("word_expected", wd_q.size() != 0, 1);
                if (wd_q.size() != 0) check_val("word", data_rx_data_o, wd_q.pop_front());
                hs_total++;
                stall_left = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rx_done_o) done_seen++;
    end

    task automatic issue(input logic [7:0] m, input logic [15:0] a, input logic [15:0] s);
        int          nw;
        int          nr;
        rd_t         e;
        logic [63:0] w;
        @(negedge clk);
        push_cmd_req_i = 1'b1;
        mram_mode_i    = m;
        data_rx_addr_i = a;
        data_rx_size_i = s;
        if (m == 8'h40) begin
            nw = (s == 0) ? 1 : (int'(s) + 3) / 4;
            nr = (nw + 1) / 2;
            for (int i = 0; i < nr; i++) begin
                e.a   = a + 16'(i);
                e.eot = (i == nr - 1);
                rd_q.push_back(e);
            end
            for (int i = 0; i < nw; i++) begin
                w = mem_word(a + 16'(i / 2));
                wd_q.push_back((i % 2 == 1) ? w[63:32] : w[31:0]);
            end
            exp_done++;
        end
        #1;
        check_val("cmd_gnt", push_cmd_gnt_o, 1);
        @(negedge clk);
        push_cmd_req_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((rd_q.size() != 0 || wd_q.size() != 0 || done_seen != exp_done || pending_o) && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("xfer_complete", n < limit, 1);
        check_val("done_count", done_seen, exp_done);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst            = 1'b1;
        push_cmd_req_i = 1'b0;
        mram_mode_i    = '0;
        data_rx_addr_i = '0;
        data_rx_size_i = '0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {push_cmd_gnt_o, mem_req_o, mem_eot_o, mem_addr_o, data_rx_valid_o,
                   data_rx_data_o, pending_o, rx_done_o}, '0);
        rst = 1'b0;

        // 8 bytes: one read, two words
        rand_rdy = 1'b0;
        ovr_en   = 1'b1;
        ovr_val  = 64'h11111111_22222222;
        issue(8'h40, 16'h0010, 16'd8);
        wait_idle(200);
        ovr_en = 1'b0;

        // partial and zero sizes round up to one word
        issue(8'h40, 16'h0100, 16'd3);
        wait_idle(200);
        issue(8'h40, 16'h0200, 16'd0);
        wait_idle(200);

        // address wrap over three reads
        rand_rdy = 1'b1;
        issue(8'h40, 16'hFFFF, 16'd24);
        wait_idle(400);
        issue(8'h40, 16'h0A00, 16'd5);
        wait_idle(300);
        issue(8'h40, 16'h0B00, 16'd9);
        wait_idle(300);

        // stall the PUSH_HI word with a following read still outstanding
        rand_rdy = 1'b0;
        stall_at = hs_total + 1;
        issue(8'h40, 16'h0300, 16'd16);
        wait_idle(300);
        stall_at = -1;

        // non-read opcode is granted and dropped
        issue(8'h02, 16'h0400, 16'd8);
        #1;
        check_val("bad_mode_idle", {pending_o, mem_req_o, push_cmd_gnt_o}, 3'b000);
        repeat (5) @(negedge clk);
        check_val("bad_mode_no_done", done_seen, exp_done);

        ovr_en  = 1'b1;
        ovr_val = 64'h0000_0000_0000_00A5;
        issue(8'h40, 16'h0500, 16'd4);
        wait_idle(200);
        ovr_en = 1'b0;

        rand_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            issue(8'h40, 16'($urandom), 16'($urandom_range(0, 40)));
            wait_idle(1000);
        end

        // reset while a word is offered
        hold_rdy = 1'b1;
        issue(8'h40, 16'h0600, 16'd8);
        n = 0;
        while (!data_rx_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("reached_push_lo", data_rx_valid_o, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_val("abort_outputs", {data_rx_valid_o, rx_done_o, pending_o, mem_req_o}, 4'b0000);
        rst = 1'b0;
        wd_q.delete();
        rd_q.delete();
        exp_done--;
        hold_rdy = 1'b0;
        repeat (5) @(negedge clk);
        check_val("abort_no_done", done_seen, exp_done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
